// File: rtl/bawsss_mem_arbiter_if.sv
// Request/response and memory bus bundle for the two-requester memory arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory side.
interface bawsss_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_rvalid;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_rvalid;
    logic [DATA_W-1:0] req1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req0_rvalid, req0_rdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/bawsss_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU data port
// and the loader/debug port, with an issue/wait/respond access sequence.
module bawsss_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bawsss_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t            state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              gnt_id_reg, gnt_id_next;
    logic [2:0]        lat_cnt_reg, lat_cnt_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [1:0]        valid_vec;
    logic [1:0]        ready_vec;
    logic [1:0]        rvalid_vec;
    logic              win_id;
    logic              cap_en;
    logic              mem_en;
    logic              mem_we;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            gnt_id_reg     <= 1'b0;
            lat_cnt_reg    <= 3'd0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            gnt_id_reg     <= gnt_id_next;
            lat_cnt_reg    <= lat_cnt_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        gnt_id_next     = gnt_id_reg;
        lat_cnt_next    = lat_cnt_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        ready_vec       = 2'b00;
        rvalid_vec      = 2'b00;
        cap_en          = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        // On a tie the requester that did not win last time takes the slot.
        win_id          = (valid_vec == 2'b11) ? ~last_grant_reg : valid_vec[1];

        case (state_reg)
            IDLE: begin
                if (rst && (valid_vec != 2'b00)) begin
                    ready_vec[win_id] = 1'b1;
                    gnt_id_next       = win_id;
                    last_grant_next   = win_id;
                    we_next           = win_id ? bus.req1_write : bus.req0_write;
                    addr_next         = win_id ? bus.req1_addr  : bus.req0_addr;
                    wdata_next        = win_id ? bus.req1_wdata : bus.req0_wdata;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_we = we_reg;
                if (we_reg) begin
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = LAT_INIT;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_next = lat_cnt_reg - 3'd1;
                if (lat_cnt_reg == 3'd1) begin
                    cap_en     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rvalid_vec[gnt_id_reg] = 1'b1;
                state_next             = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdata_reg[gi] <= '0;
                end else if (cap_en && (gnt_id_reg == 1'(gi))) begin
                    rdata_reg[gi] <= bus.mem_rdata;
                end
            end
        end
    endgenerate

    assign bus.req0_ready  = ready_vec[0];
    assign bus.req1_ready  = ready_vec[1];
    assign bus.req0_rvalid = rvalid_vec[0];
    assign bus.req1_rvalid = rvalid_vec[1];
    assign bus.req0_rdata  = rdata_reg[0];
    assign bus.req1_rdata  = rdata_reg[1];
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_wdata   = wdata_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_bawsss_mem_arbiter.sv
// Self-checking bench for bawsss_mem_arbiter: a transaction-level model predicts
// grants, memory strobes and read responses cycle by cycle from the timing rules.
module tb_bawsss_mem_arbiter;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bawsss_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    bawsss_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

    bawsss_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    bawsss_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    function automatic logic [15:0] init_val(input logic [7:0] a);
        logic [15:0] t;
        t = {8'h00, a} - 16'h0020;
        return 16'h1234 + t * 16'h0101;
    endfunction

    // Memory with LAT-cycle read pipeline; poison outside the valid read slot.
    logic [15:0] tbmem [0:255];
    logic [15:0] pipe  [0:LAT-1];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) tbmem[i] <= init_val(8'(i));
        end else if (bus.mem_en && bus.mem_we) begin
            tbmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? tbmem[bus.mem_addr[7:0]] : 16'hDEAD;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    logic [15:0] rd1;
    always @(posedge clk)
        rd1 <= (bus1.mem_en && !bus1.mem_we) ?
               ((bus1.mem_addr == 16'h0020) ? 16'h1234 : 16'h0BAD) : 16'hDEAD;
    assign bus1.mem_rdata = rd1;

    int tests = 0;
    int fails = 0;
    int now   = 0;

    // Reference model state
    logic [15:0] shadow [0:255];
    logic        m_last;
    int          idle_from, en_cyc, resp_cyc;
    logic        en_we;
    logic [15:0] en_addr, en_data, resp_data;
    int          resp_id;
    logic [15:0] exp_rd [2];
    int          grants [$];

    // Requester stimulus state
    logic        v [2];
    logic        w [2];
    logic [15:0] a [2];
    logic [15:0] d [2];
    int          gen_pct [2];
    int          wr_mode;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cycle %0d: observed %h expected %h", tag, now, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last    = 1'b1;
        idle_from = now;
        en_cyc    = -1;
        resp_cyc  = -1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    endtask

    task automatic drive();
        bus.req0_valid = v[0]; bus.req0_write = w[0]; bus.req0_addr = a[0]; bus.req0_wdata = d[0];
        bus.req1_valid = v[1]; bus.req1_write = w[1]; bus.req1_addr = a[1]; bus.req1_wdata = d[1];
    endtask

    task automatic step_cycle();
        int win;
        for (int r = 0; r < 2; r++) begin
            if (!v[r] && (int'($urandom_range(1, 100)) <= gen_pct[r])) begin
                v[r] = 1'b1;
                w[r] = (wr_mode == 1) ? 1'b1 : (wr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                a[r] = 16'($urandom_range(0, 255));
                d[r] = 16'($urandom);
            end
        end
        drive();
        #1;
        win = -1;
        if (now >= idle_from) begin
            if (v[0] && v[1]) win = m_last ? 0 : 1;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end
        if (now == resp_cyc) exp_rd[resp_id] = resp_data;
        chk("req0_ready", 16'(bus.req0_ready), 16'(win == 0));
        chk("req1_ready", 16'(bus.req1_ready), 16'(win == 1));
        chk("busy", 16'(bus.busy), 16'(now < idle_from));
        chk("mem_en", 16'(bus.mem_en), 16'(now == en_cyc));
        if (now == en_cyc) begin
            chk("mem_we", 16'(bus.mem_we), 16'(en_we));
            chk("mem_addr", bus.mem_addr, en_addr);
            chk("mem_wdata", bus.mem_wdata, en_data);
        end
        chk("req0_rvalid", 16'(bus.req0_rvalid), 16'(now == resp_cyc && resp_id == 0));
        chk("req1_rvalid", 16'(bus.req1_rvalid), 16'(now == resp_cyc && resp_id == 1));
        chk("req0_rdata", bus.req0_rdata, exp_rd[0]);
        chk("req1_rdata", bus.req1_rdata, exp_rd[1]);
        if (win >= 0) begin
            grants.push_back(win);
            m_last  = 1'(win);
            en_cyc  = now + 1;
            en_we   = w[win];
            en_addr = a[win];
            en_data = d[win];
            if (w[win]) begin
                shadow[a[win][7:0]] = d[win];
                idle_from = now + 2;
            end else begin
                resp_cyc  = now + 2 + LAT;
                resp_id   = win;
                resp_data = shadow[a[win][7:0]];
                idle_from = now + 3 + LAT;
            end
            $display("[TB] cycle %0d grant req%0d %s addr=%h data=%h", now, win,
                     w[win] ? "WR" : "RD", a[win], w[win] ? d[win] : resp_data);
            v[win] = 1'b0;
        end
        @(posedge clk); #1; now++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; now++; #1;
            chk("rst_ready0", 16'(bus.req0_ready), 16'd0);
            chk("rst_ready1", 16'(bus.req1_ready), 16'd0);
            chk("rst_rvalid", 16'({bus.req0_rvalid, bus.req1_rvalid}), 16'd0);
            chk("rst_rdata0", bus.req0_rdata, 16'd0);
            chk("rst_rdata1", bus.req1_rdata, 16'd0);
            chk("rst_mem", 16'({bus.mem_en, bus.mem_we}), 16'd0);
            chk("rst_mem_addr", bus.mem_addr, 16'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 16'd0);
            chk("rst_busy", 16'(bus.busy), 16'd0);
        end
        rst = 1'b1;
        model_reset();
        $display("[TB] cycle %0d reset released after %0d cycles", now, n);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    initial begin
        int cnt1;
        bus1.req0_valid = 1'b0; bus1.req0_write = 1'b0; bus1.req0_addr = '0; bus1.req0_wdata = '0;
        bus1.req1_valid = 1'b0; bus1.req1_write = 1'b0; bus1.req1_addr = '0; bus1.req1_wdata = '0;
        gen_pct[0] = 0; gen_pct[1] = 0; wr_mode = 0;
        // Reset with both valid: req0 write 0x0010/0xBEEF, req1 read of 0x0020.
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 16'h0010; d[0] = 16'hBEEF;
        v[1] = 1'b1; w[1] = 1'b0; a[1] = 16'h0020; d[1] = 16'h0000;
        drive();
        do_reset(3);
        run(12);
        chk("tie_first_grant", 16'(grants[0]), 16'd0);
        chk("second_grant", 16'(grants[1]), 16'd1);
        chk("req1_read_1234", bus.req1_rdata, 16'h1234);
        chk("req0_rdata_untouched", bus.req0_rdata, 16'h0000);

        // Latency-1 instance: req1 read of 0x0020, rvalid exactly in cycle 3.
        for (int c = 0; c < 6; c++) begin
            bus1.req1_valid = (c == 0); bus1.req1_write = 1'b0; bus1.req1_addr = 16'h0020;
            #1;
            if (c == 0) chk("l1_ready1", 16'(bus1.req1_ready), 16'd1);
            chk("l1_rvalid1", 16'(bus1.req1_rvalid), 16'(c == 3));
            chk("l1_rvalid0", 16'(bus1.req0_rvalid), 16'd0);
            if (c == 3) chk("l1_rdata1", bus1.req1_rdata, 16'h1234);
            $display("[TB] l1 cycle %0d rvalid1=%0d rdata1=%h", c, bus1.req1_rvalid, bus1.req1_rdata);
            @(posedge clk); #1; now++;
        end

        // Contention: both always valid, grants must alternate starting with req0.
        grants.delete();
        gen_pct[0] = 100; gen_pct[1] = 100; wr_mode = 0;
        run(60);
        chk("contention_count", 16'(grants.size() >= 8), 16'd1);
        for (int i = 0; i < grants.size(); i++) chk("contention_alt", 16'(grants[i]), 16'(i % 2));

        // Drain, then back-to-back writes from req1 only.
        gen_pct[0] = 0; gen_pct[1] = 0;
        run(15);
        grants.delete();
        gen_pct[1] = 100; wr_mode = 1;
        run(20);
        cnt1 = 0;
        foreach (grants[i]) if (grants[i] == 1) cnt1++;
        chk("b2b_writes", 16'(cnt1), 16'd10);

        // Randomized mixed traffic.
        gen_pct[0] = 40; gen_pct[1] = 40; wr_mode = 0;
        run(400);

        // Reset while a read is in WAIT: no rvalid, rdata cleared.
        gen_pct[0] = 0; gen_pct[1] = 0;
        run(15);
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 16'h0020; d[0] = 16'h0;
        run(3);
        do_reset(2);
        run(10);
        chk("wait_rst_rdata0", bus.req0_rdata, 16'h0000);
        chk("wait_rst_idle", 16'(bus.busy), 16'd0);

        gen_pct[0] = 50; gen_pct[1] = 30; wr_mode = 0;
        run(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
